// File: rtl/filter_3x3_ctrl_if.sv
// Configuration handshake between the register block (master) and filter_3x3_ctrl (slave).
interface filter_3x3_ctrl_if;
  logic cfg_en;
  logic cfg_valid;
  logic cfg_ready;

  modport master (output cfg_en, output cfg_valid, input cfg_ready);
  modport slave  (input cfg_en, input cfg_valid, output cfg_ready);
endinterface

// File: rtl/filter_3x3_ctrl.sv
// Frame-synchronous bypass/geometry controller for the 3x3 filter core; commit results appear 2 cycles after vs_i falls.
// Config handshake holds one pending entry; cfg_ready stays low until that entry is applied between frames.
module filter_3x3_ctrl #(
  parameter int LINE_SIZE_MAX   = 1024,
  parameter int FRAME_LINES_MAX = 4096,
  parameter bit AUTO_BYPASS     = 1'b1,
  localparam int WX = $clog2(LINE_SIZE_MAX) + 1,
  localparam int WY = $clog2(FRAME_LINES_MAX) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             de_i,
  input  logic             hs_i,
  input  logic             vs_i,
  filter_3x3_ctrl_if.slave cfg,
  input  logic             err_clr,
  output logic             core_bypass,
  output logic [WX-1:0]    meas_width,
  output logic [WY-1:0]    meas_height,
  output logic [15:0]      frame_cnt,
  output logic             err_wide,
  output logic             err_small,
  output logic             err_ragged
);

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] WAIT_FRAME = 2'd1;
  localparam logic [1:0] IN_FRAME   = 2'd2;

  localparam logic [WX-1:0] PIX_MAX  = '1;
  localparam logic [WY-1:0] LINE_SAT = '1;
  localparam logic [WX-1:0] W_MAX    = WX'(LINE_SIZE_MAX);
  localparam logic [WX-1:0] W_MIN    = WX'(3);
  localparam logic [WY-1:0] H_MIN    = WY'(3);

  logic [1:0]    state;
  logic          de_d, hs_d, vs_d, hs_d2, vs_d2;
  logic [WX-1:0] pix_cnt, ref_w, last_w;
  logic [WY-1:0] line_cnt;
  logic          wide_f, rag_f;
  logic          pending, pend_en, en_active, force_q;

  logic          hs_fall, vs_fall, vs_rise, in_frame, counting;
  logic [WX-1:0] cnt_now, fin_w;
  logic [WY-1:0] line_inc, fin_h;
  logic          line_close, line_wide, line_rag;
  logic          fr_wide, fr_rag, fr_small;
  logic          commit, apply_now, hs_acc, en_next, force_next;

  assign cfg.cfg_ready = ~pending;

  always_comb begin
    hs_fall    = hs_d2 & ~hs_d;
    vs_fall    = vs_d2 & ~vs_d;
    vs_rise    = vs_d & ~vs_d2;
    in_frame   = (state == IN_FRAME);
    // The first pixel of a frame can arrive in the same cycle the rising edge is seen.
    counting   = vs_d & (in_frame | ((state == WAIT_FRAME) & vs_rise));
    cnt_now    = pix_cnt;
    if (counting && de_d && (pix_cnt != PIX_MAX))
      cnt_now = pix_cnt + WX'(1);
    line_close = in_frame & (cnt_now != '0) & ((hs_fall & vs_d) | vs_fall);
    line_inc   = (line_cnt == LINE_SAT) ? line_cnt : line_cnt + WY'(1);
    line_wide  = (cnt_now > W_MAX);
    line_rag   = (line_cnt != '0) & (cnt_now != ref_w);
    fin_w      = line_close ? cnt_now : last_w;
    fin_h      = line_close ? line_inc : line_cnt;
    fr_wide    = wide_f | (line_close & line_wide);
    fr_rag     = rag_f | (line_close & line_rag);
    fr_small   = (fin_w < W_MIN) | (fin_h < H_MIN);
    commit     = in_frame & vs_fall;
    apply_now  = ~in_frame & ~vs_i & pending;
    hs_acc     = cfg.cfg_valid & ~pending;
    en_next    = pending ? pend_en : en_active;
    force_next = AUTO_BYPASS & (fr_wide | fr_small);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      de_d        <= 1'b0;
      hs_d        <= 1'b0;
      vs_d        <= 1'b0;
      hs_d2       <= 1'b0;
      vs_d2       <= 1'b0;
      pix_cnt     <= '0;
      ref_w       <= '0;
      last_w      <= '0;
      line_cnt    <= '0;
      wide_f      <= 1'b0;
      rag_f       <= 1'b0;
      pending     <= 1'b0;
      pend_en     <= 1'b0;
      en_active   <= 1'b0;
      force_q     <= 1'b0;
      core_bypass <= 1'b1;
      meas_width  <= '0;
      meas_height <= '0;
      frame_cnt   <= '0;
      err_wide    <= 1'b0;
      err_small   <= 1'b0;
      err_ragged  <= 1'b0;
    end else begin
      de_d  <= de_i;
      hs_d  <= hs_i;
      vs_d  <= vs_i;
      hs_d2 <= hs_d;
      vs_d2 <= vs_d;

      case (state)
        IDLE:       if (!vs_i) state <= WAIT_FRAME;
        WAIT_FRAME: if (vs_rise) state <= IN_FRAME;
        IN_FRAME:   if (vs_fall) state <= WAIT_FRAME;
        default:    state <= IDLE;
      endcase

      err_wide   <= err_wide & ~err_clr;
      err_small  <= err_small & ~err_clr;
      err_ragged <= err_ragged & ~err_clr;

      if (counting) pix_cnt <= cnt_now;

      if (line_close) begin
        pix_cnt  <= '0;
        line_cnt <= line_inc;
        last_w   <= cnt_now;
        wide_f   <= wide_f | line_wide;
        rag_f    <= rag_f | line_rag;
        if (line_cnt == '0) ref_w <= cnt_now;
      end

      if (commit) begin
        meas_width  <= fin_w;
        meas_height <= fin_h;
        frame_cnt   <= frame_cnt + 16'd1;
        err_wide    <= (err_wide & ~err_clr) | fr_wide;
        err_small   <= (err_small & ~err_clr) | fr_small;
        err_ragged  <= (err_ragged & ~err_clr) | fr_rag;
        pending     <= 1'b0;
        en_active   <= en_next;
        force_q     <= force_next;
        core_bypass <= ~en_next | force_next;
        pix_cnt     <= '0;
        line_cnt    <= '0;
        last_w      <= '0;
        ref_w       <= '0;
        wide_f      <= 1'b0;
        rag_f       <= 1'b0;
      end

      // A config accepted in the commit cycle stays pending for the next gap.
      if (hs_acc) begin
        pending <= 1'b1;
        pend_en <= cfg.cfg_en;
      end else if (apply_now) begin
        pending     <= 1'b0;
        en_active   <= pend_en;
        core_bypass <= ~pend_en | force_q;
      end
    end
  end

endmodule

// File: tb/tb_filter_3x3_ctrl.sv
// Directed bench for filter_3x3_ctrl: frame-table vectors plus mid-frame config and mid-frame reset sequences.
module tb_filter_3x3_ctrl;

  localparam int LSM = 16;
  localparam int WX  = $clog2(LSM) + 1;
  localparam int WY  = $clog2(4096) + 1;

  logic          clk = 1'b0;
  logic          rst, de_i, hs_i, vs_i, err_clr;
  logic          core_bypass, err_wide, err_small, err_ragged;
  logic [WX-1:0] meas_width;
  logic [WY-1:0] meas_height;
  logic [15:0]   frame_cnt;

  filter_3x3_ctrl_if cfg_if ();

  filter_3x3_ctrl #(.LINE_SIZE_MAX(LSM), .FRAME_LINES_MAX(4096), .AUTO_BYPASS(1'b1)) dut (
    .clk(clk), .rst(rst), .de_i(de_i), .hs_i(hs_i), .vs_i(vs_i), .cfg(cfg_if),
    .err_clr(err_clr), .core_bypass(core_bypass), .meas_width(meas_width),
    .meas_height(meas_height), .frame_cnt(frame_cnt), .err_wide(err_wide),
    .err_small(err_small), .err_ragged(err_ragged)
  );

  always #5 clk = ~clk;

  typedef struct {
    int nl; int wid; int lastw; bit coinc; bit clr;
    int ew; int eh; int ewide; int esmall; int erag; int ebyp;
  } vec_t;

  vec_t tbl [8];
  int   checks   = 0;
  int   failures = 0;
  int   exp_fc   = 0;
  int   glitch   = 0;
  bit   mon_en   = 1'b0;
  logic mon_ref  = 1'b0;

  always @(negedge clk)
    if (mon_en && vs_i && (core_bypass !== mon_ref)) glitch++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cfg_hs(input logic en);
    cfg_if.cfg_en    = en;
    cfg_if.cfg_valid = 1'b1;
    tick();
    cfg_if.cfg_valid = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    tick();
  endtask

  // cfg_line >= 0 offers cfg_en=0 on that line and a rejected cfg_en=1 on the next line.
  task automatic send_frame(input int nl, input int wid, input int lastw, input bit coinc, input int cfg_line);
    int w;
    vs_i = 1'b1;
    tick();
    tick();
    for (int l = 0; l < nl; l++) begin
      w = (l == nl - 1) ? lastw : wid;
      hs_i = 1'b1;
      tick();
      for (int p = 0; p < w; p++) begin
        de_i = 1'b1;
        if (cfg_line >= 0 && p == 0 && l == cfg_line) begin
          cfg_if.cfg_en = 1'b0; cfg_if.cfg_valid = 1'b1;
        end
        if (cfg_line >= 0 && p == 0 && l == cfg_line + 1) begin
          cfg_if.cfg_en = 1'b1; cfg_if.cfg_valid = 1'b1;
        end
        tick();
        cfg_if.cfg_valid = 1'b0;
        if (cfg_line >= 0 && p == 0 && l == cfg_line) check("ready_after_hs", cfg_if.cfg_ready, 0);
      end
      de_i = 1'b0;
      hs_i = 1'b0;
      if (coinc && l == nl - 1) vs_i = 1'b0;
      tick();
      tick();
    end
    if (vs_i) begin
      vs_i = 1'b0;
      tick();
      if (cfg_line >= 0) check("ready_before_commit", cfg_if.cfg_ready, 0);
      tick();
    end
  endtask

  task automatic check_frame(input string tag, input int ew, input int eh, input int ewide,
                             input int esmall, input int erag, input int ebyp);
    check({tag, "_width"},  meas_width, ew);
    check({tag, "_height"}, meas_height, eh);
    check({tag, "_fcnt"},   frame_cnt, exp_fc);
    check({tag, "_wide"},   err_wide, ewide);
    check({tag, "_small"},  err_small, esmall);
    check({tag, "_ragged"}, err_ragged, erag);
    check({tag, "_bypass"}, core_bypass, ebyp);
    check({tag, "_ready"},  cfg_if.cfg_ready, 1);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_bypass"}, core_bypass, 1);
    check({tag, "_ready"},  cfg_if.cfg_ready, 1);
    check({tag, "_width"},  meas_width, 0);
    check({tag, "_height"}, meas_height, 0);
    check({tag, "_fcnt"},   frame_cnt, 0);
    check({tag, "_errs"},   {err_wide, err_small, err_ragged}, 0);
  endtask

  initial begin
    //         nl  wid lastw coinc clr  ew  eh wide small rag byp
    tbl[0] = '{6,  8,  8,    1'b0, 1'b0, 8, 6, 0,   0,    0,  0};
    tbl[1] = '{6,  5,  5,    1'b1, 1'b0, 5, 6, 0,   0,    0,  0};
    tbl[2] = '{4,  17, 17,   1'b0, 1'b0, 17, 4, 1,  0,    0,  1};
    tbl[3] = '{4,  16, 16,   1'b0, 1'b0, 16, 4, 1,  0,    0,  0};
    tbl[4] = '{2,  2,  2,    1'b0, 1'b1, 2, 2, 0,   1,    0,  1};
    tbl[5] = '{3,  8,  7,    1'b0, 1'b1, 7, 3, 0,   0,    1,  0};
    tbl[6] = '{0,  0,  0,    1'b0, 1'b1, 0, 0, 0,   1,    0,  1};
    tbl[7] = '{3,  3,  3,    1'b1, 1'b1, 3, 3, 0,   0,    0,  0};

    rst = 1'b1; de_i = 1'b0; hs_i = 1'b0; vs_i = 1'b0; err_clr = 1'b0;
    cfg_if.cfg_en = 1'b0; cfg_if.cfg_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    check_reset("rst");

    cfg_hs(1'b1);
    tick();
    check("bypass_cfg_blank", core_bypass, 0);
    check("ready_after_apply", cfg_if.cfg_ready, 1);

    for (int i = 0; i < 8; i++) begin
      if (tbl[i].clr) pulse_clr();
      send_frame(tbl[i].nl, tbl[i].wid, tbl[i].lastw, tbl[i].coinc, -1);
      exp_fc++;
      check_frame($sformatf("v%0d", i), tbl[i].ew, tbl[i].eh, tbl[i].ewide,
                  tbl[i].esmall, tbl[i].erag, tbl[i].ebyp);
    end

    // Mid-frame config: bypass frozen during the frame, second offer refused while one is pending.
    glitch = 0; mon_ref = 1'b0; mon_en = 1'b1;
    send_frame(6, 8, 8, 1'b0, 2);
    mon_en = 1'b0;
    exp_fc++;
    check("midcfg_glitch", glitch, 0);
    check_frame("midcfg", 8, 6, 0, 0, 0, 1);
    repeat (3) tick();
    check("midcfg_second_refused", core_bypass, 1);

    cfg_hs(1'b1);
    check("ready_pending_blank", cfg_if.cfg_ready, 0);
    tick();
    check("bypass_reenable", core_bypass, 0);

    // Mid-frame reset: partial frame discarded, next frame measured from scratch.
    vs_i = 1'b1; tick(); tick();
    hs_i = 1'b1; de_i = 1'b1;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset("midrst");
    repeat (3) tick();
    de_i = 1'b0; hs_i = 1'b0; tick();
    vs_i = 1'b0;
    repeat (4) tick();
    check("midrst_no_commit", frame_cnt, 0);
    check("midrst_bypass_hold", core_bypass, 1);
    cfg_hs(1'b1);
    tick();
    check("midrst_bypass_cfg", core_bypass, 0);
    send_frame(6, 8, 8, 1'b0, -1);
    exp_fc = 1;
    check_frame("postrst", 8, 6, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
